bp_be_fe_cmd_issuer: RTL and testbench



---
 rtl/bp_be_fe_cmd_issuer.sv | 203 ++++++++++++++++++++
 tb/tb_bp_be_fe_cmd_issuer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_fe_cmd_issuer.sv
// BE-side FE command issuer: fe_cmd FIFO (opcode in top 4 bits), fe_queue forwarding, stale-beat discard.
// Latency: fe_cmd one cycle min (registered FIFO, no bypass); fe_queue->fetch zero cycles in e_run.
// Backpressure: req ready on ~full (attaboy always ready, dropped when full); fe_queue follows issue ready. Stats gated by BP_BE_FE_CMD_STATS_EN.

module bp_be_fe_cmd_fifo
  #(parameter int width_p = 8
  , parameter int els_p   = 4
  )
   (input  logic               clk
  , input  logic               reset_n
  , input  logic               enq
  , input  logic               deq
  , input  logic [width_p-1:0] wdata
  , output logic [width_p-1:0] rdata
  , output logic               empty
  , output logic               full
  );

    localparam int ptr_width_lp = $clog2(els_p) + 1;

    logic [width_p-1:0]      mem [els_p];
    logic [ptr_width_lp-1:0] wptr, rptr;
    logic [ptr_width_lp-2:0] waddr, raddr;

    assign waddr = wptr[ptr_width_lp-2:0];
    assign raddr = rptr[ptr_width_lp-2:0];

    // The extra pointer bit tells a full ring from an empty one.
    assign empty = (wptr == rptr);
    assign full  = (wptr[ptr_width_lp-1] != rptr[ptr_width_lp-1]) && (waddr == raddr);
    assign rdata = mem[raddr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq) wptr <= wptr + 1'b1;
            if (deq) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[waddr] <= wdata;
    end

endmodule

module bp_be_fe_cmd_issuer
  #(parameter int vaddr_width_p               = 39
  , parameter int branch_metadata_fwd_width_p = 36
  , parameter int cmd_fifo_els_p              = 4
  , localparam int fe_cmd_width_lp   = 4 + vaddr_width_p + branch_metadata_fwd_width_p
  , localparam int fe_queue_width_lp = 2 + vaddr_width_p + 32 + branch_metadata_fwd_width_p
  )
   (input  logic                         clk_i
  , input  logic                         reset_n_i
  , input  logic                         req_v_i
  , input  logic [fe_cmd_width_lp-1:0]   req_cmd_i
  , output logic                         req_ready_and_o
  , output logic [fe_cmd_width_lp-1:0]   fe_cmd_o
  , output logic                         fe_cmd_v_o
  , input  logic                         fe_cmd_yumi_i
  , input  logic [fe_queue_width_lp-1:0] fe_queue_i
  , input  logic                         fe_queue_v_i
  , output logic                         fe_queue_ready_and_o
  , output logic [fe_queue_width_lp-1:0] fetch_pkt_o
  , output logic                         fetch_v_o
  , input  logic                         fetch_ready_and_i
  , output logic                         fe_quiesced_o
  , output logic [15:0]                  stat_attaboy_drop_o
  , output logic [15:0]                  stat_stale_drop_o
  );

    localparam int cnt_width_lp = $clog2(cmd_fifo_els_p + 1);

    localparam logic [3:0] e_op_state_reset = 4'd0;
    localparam logic [3:0] e_op_attaboy     = 4'd6;

    localparam logic [1:0] e_reset = 2'd0;
    localparam logic [1:0] e_run   = 2'd1;
    localparam logic [1:0] e_flush = 2'd2;

    logic [1:0]              state_r, state_n;
    logic [cnt_width_lp-1:0] cnt_r, cnt_n;
    logic [3:0]              req_op, head_op;
    logic                    req_attaboy;
    logic                    fifo_full, fifo_empty;
    logic                    accept, cmd_yumi, attaboy_drop, enq;
    logic                    cnt_inc, cnt_dec;

    assign req_op      = req_cmd_i[fe_cmd_width_lp-1 -: 4];
    assign head_op     = fe_cmd_o[fe_cmd_width_lp-1 -: 4];
    assign req_attaboy = (req_op == e_op_attaboy);

    always_comb begin
        req_ready_and_o = 1'b0;
        if (state_r == e_reset)
            req_ready_and_o = ~fifo_full & (req_op == e_op_state_reset);
        else if (req_attaboy)
            req_ready_and_o = 1'b1;
        else
            req_ready_and_o = ~fifo_full;
    end

    assign accept   = req_v_i & req_ready_and_o;
    assign cmd_yumi = fe_cmd_yumi_i & ~fifo_empty;
    // A full FIFO freed by this cycle's yumi still has room for the attaboy.
    assign attaboy_drop = accept & req_attaboy & fifo_full & ~cmd_yumi;
    assign enq          = accept & ~attaboy_drop;

    bp_be_fe_cmd_fifo
     #(.width_p (fe_cmd_width_lp)
      ,.els_p   (cmd_fifo_els_p)
      )
     cmd_fifo
      (.clk     (clk_i)
      ,.reset_n (reset_n_i)
      ,.enq     (enq)
      ,.deq     (cmd_yumi)
      ,.wdata   (req_cmd_i)
      ,.rdata   (fe_cmd_o)
      ,.empty   (fifo_empty)
      ,.full    (fifo_full)
      );

    assign fe_cmd_v_o = ~fifo_empty;

    assign cnt_inc = accept & ~req_attaboy;
    assign cnt_dec = cmd_yumi & (head_op != e_op_attaboy);

    always_comb begin
        cnt_n = cnt_r;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_n = cnt_r + 1'b1;
            2'b01:   cnt_n = cnt_r - 1'b1;
            default: cnt_n = cnt_r;
        endcase
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_reset: if (accept)       state_n = e_flush;
            e_run:   if (cnt_inc)      state_n = e_flush;
            e_flush: if (cnt_n == '0)  state_n = e_run;
            default:                   state_n = e_reset;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_reset;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Outside e_run the FE stream is stale: sink it without forwarding.
    always_comb begin
        fetch_v_o            = 1'b0;
        fe_queue_ready_and_o = 1'b1;
        if (state_r == e_run) begin
            fetch_v_o            = fe_queue_v_i & ~cnt_inc;
            fe_queue_ready_and_o = fetch_ready_and_i;
        end
    end

    assign fetch_pkt_o   = fe_queue_i;
    assign fe_quiesced_o = fifo_empty & (state_r == e_run);

`ifdef BP_BE_FE_CMD_STATS_EN
    logic        stale_drop;
    logic [15:0] attaboy_cnt_r, stale_cnt_r;

    assign stale_drop = (state_r != e_run) & fe_queue_v_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            attaboy_cnt_r <= '0;
            stale_cnt_r   <= '0;
        end else begin
            if (attaboy_drop && (attaboy_cnt_r != 16'hFFFF)) attaboy_cnt_r <= attaboy_cnt_r + 1'b1;
            if (stale_drop   && (stale_cnt_r   != 16'hFFFF)) stale_cnt_r   <= stale_cnt_r + 1'b1;
        end
    end

    assign stat_attaboy_drop_o = attaboy_cnt_r;
    assign stat_stale_drop_o   = stale_cnt_r;
`else
    assign stat_attaboy_drop_o = '0;
    assign stat_stale_drop_o   = '0;
`endif

    a_yumi_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fe_cmd_yumi_i |-> fe_cmd_v_o);

    a_cnt_bounded: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        cnt_r <= cnt_width_lp'(cmd_fifo_els_p));

endmodule

// File: tb/tb_bp_be_fe_cmd_issuer.sv
// Scoreboard bench for bp_be_fe_cmd_issuer: inputs driven just after negedge, outputs sampled 1ns later.
module tb_bp_be_fe_cmd_issuer;

    localparam int VA = 39;
    localparam int BM = 36;
    localparam int CW = 4 + VA + BM;
    localparam int QW = 2 + VA + 32 + BM;

    localparam logic [3:0] OP_STATE_RESET = 4'd0;
    localparam logic [3:0] OP_REDIRECT    = 4'd1;
    localparam logic [3:0] OP_ICACHE_FILL = 4'd2;
    localparam logic [3:0] OP_ITLB_FENCE  = 4'd5;
    localparam logic [3:0] OP_ATTABOY     = 4'd6;

`ifdef BP_BE_FE_CMD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_v;
    logic [CW-1:0] req_cmd;
    logic          req_ready_and_o;
    logic [CW-1:0] fe_cmd_o;
    logic          fe_cmd_v_o;
    logic          fe_cmd_yumi;
    logic [QW-1:0] fe_queue;
    logic          fe_queue_v;
    logic          fe_queue_ready_and_o;
    logic [QW-1:0] fetch_pkt_o;
    logic          fetch_v_o;
    logic          fetch_ready_and;
    logic          fe_quiesced_o;
    logic [15:0]   stat_attaboy_drop_o;
    logic [15:0]   stat_stale_drop_o;

    int cmp  = 0;
    int errs = 0;

    logic [CW-1:0] cmd_q [$];
    logic [QW-1:0] pkt_q [$];
    logic [CW-1:0] exp_cmd;
    logic [QW-1:0] exp_pkt;
    logic [15:0]   exp_stale;
    logic [15:0]   exp_attaboy;

    always #5 clk = ~clk;

    bp_be_fe_cmd_issuer dut
      (.clk_i                (clk)
      ,.reset_n_i            (reset_n)
      ,.req_v_i              (req_v)
      ,.req_cmd_i            (req_cmd)
      ,.req_ready_and_o      (req_ready_and_o)
      ,.fe_cmd_o             (fe_cmd_o)
      ,.fe_cmd_v_o           (fe_cmd_v_o)
      ,.fe_cmd_yumi_i        (fe_cmd_yumi)
      ,.fe_queue_i           (fe_queue)
      ,.fe_queue_v_i         (fe_queue_v)
      ,.fe_queue_ready_and_o (fe_queue_ready_and_o)
      ,.fetch_pkt_o          (fetch_pkt_o)
      ,.fetch_v_o            (fetch_v_o)
      ,.fetch_ready_and_i    (fetch_ready_and)
      ,.fe_quiesced_o        (fe_quiesced_o)
      ,.stat_attaboy_drop_o  (stat_attaboy_drop_o)
      ,.stat_stale_drop_o    (stat_stale_drop_o)
      );

    function automatic logic [CW-1:0] mk_cmd(input logic [3:0] op);
        return {op, (CW-4)'({$urandom(), $urandom(), $urandom()})};
    endfunction

    function automatic logic [QW-1:0] mk_pkt();
        return QW'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic idle_inputs();
        req_v       = 1'b0;
        fe_cmd_yumi = 1'b0;
        fe_queue_v  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; idle_inputs(); req_cmd = '0; fe_queue = '0; fetch_ready_and = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        cmp++; if (fe_cmd_v_o !== 1'b0) begin errs++; $display("FAIL reset_fe_cmd_v got %b want 0", fe_cmd_v_o); end
        cmp++; if (fetch_v_o !== 1'b0) begin errs++; $display("FAIL reset_fetch_v got %b want 0", fetch_v_o); end
        cmp++; if (fe_quiesced_o !== 1'b0) begin errs++; $display("FAIL reset_quiesced got %b want 0", fe_quiesced_o); end
        cmp++; if (stat_attaboy_drop_o !== 16'd0 || stat_stale_drop_o !== 16'd0) begin
            errs++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_attaboy_drop_o, stat_stale_drop_o); end
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_state_reset();
        @(negedge clk);
        req_v = 1'b1; req_cmd = mk_cmd(OP_REDIRECT);
        #1;
        cmp++; if (req_ready_and_o !== 1'b0) begin errs++; $display("FAIL reset_redirect_ready got %b want 0", req_ready_and_o); end
        req_cmd = mk_cmd(OP_STATE_RESET);
        #1;
        cmp++; if (req_ready_and_o !== 1'b1) begin errs++; $display("FAIL state_reset_ready got %b want 1", req_ready_and_o); end
        cmd_q.push_back(req_cmd);
        @(negedge clk);
        req_v = 1'b0; fe_cmd_yumi = 1'b1;
        #1;
        cmp++; if (fe_cmd_v_o !== 1'b1) begin errs++; $display("FAIL state_reset_cmd_v got %b want 1", fe_cmd_v_o); end
        cmp++; exp_cmd = (cmd_q.size() != 0) ? cmd_q.pop_front() : 'x;
        if (fe_cmd_o !== exp_cmd) begin errs++; $display("FAIL state_reset_cmd got %h want %h", fe_cmd_o, exp_cmd); end
        cmp++; if (fe_quiesced_o !== 1'b0) begin errs++; $display("FAIL flush_quiesced got %b want 0", fe_quiesced_o); end
        @(negedge clk);
        fe_cmd_yumi = 1'b0;
        #1;
        cmp++; if (fe_cmd_v_o !== 1'b0) begin errs++; $display("FAIL drained_cmd_v got %b want 0", fe_cmd_v_o); end
        cmp++; if (fe_quiesced_o !== 1'b1) begin errs++; $display("FAIL run_quiesced got %b want 1", fe_quiesced_o); end
    endtask

    task automatic test_forward();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fe_queue_v = 1'b1; fetch_ready_and = 1'b1; fe_queue = mk_pkt();
            pkt_q.push_back(fe_queue);
            #1;
            cmp++; if (fetch_v_o !== 1'b1 || fe_queue_ready_and_o !== 1'b1) begin
                errs++; $display("FAIL fwd_valid[%0d] got v=%b rdy=%b want 1/1", i, fetch_v_o, fe_queue_ready_and_o); end
            cmp++; exp_pkt = (pkt_q.size() != 0) ? pkt_q.pop_front() : 'x;
            if (fetch_pkt_o !== exp_pkt) begin errs++; $display("FAIL fwd_pkt[%0d] got %h want %h", i, fetch_pkt_o, exp_pkt); end
        end
        @(negedge clk);
        fetch_ready_and = 1'b0;
        #1;
        cmp++; if (fe_queue_ready_and_o !== 1'b0) begin errs++; $display("FAIL fwd_backpressure got %b want 0", fe_queue_ready_and_o); end
        idle_inputs(); fetch_ready_and = 1'b1;
    endtask

    task automatic test_stale_discard();
        @(negedge clk);
        req_v = 1'b1; req_cmd = mk_cmd(OP_REDIRECT);
        #1;
        cmp++; if (req_ready_and_o !== 1'b1) begin errs++; $display("FAIL redirect_ready got %b want 1", req_ready_and_o); end
        cmd_q.push_back(req_cmd);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req_v = 1'b0; fe_queue_v = 1'b1; fe_queue = mk_pkt();
            #1;
            cmp++; if (fetch_v_o !== 1'b0 || fe_queue_ready_and_o !== 1'b1) begin
                errs++; $display("FAIL stale_beat[%0d] got v=%b rdy=%b want 0/1", i, fetch_v_o, fe_queue_ready_and_o); end
        end
        @(negedge clk);
        fe_queue_v = 1'b0; fe_cmd_yumi = 1'b1;
        #1;
        cmp++; exp_cmd = (cmd_q.size() != 0) ? cmd_q.pop_front() : 'x;
        if (fe_cmd_o !== exp_cmd) begin errs++; $display("FAIL redirect_cmd got %h want %h", fe_cmd_o, exp_cmd); end
        @(negedge clk);
        fe_cmd_yumi = 1'b0; fe_queue_v = 1'b1; fe_queue = mk_pkt();
        pkt_q.push_back(fe_queue);
        #1;
        cmp++; exp_pkt = (pkt_q.size() != 0) ? pkt_q.pop_front() : 'x;
        if (fetch_v_o !== 1'b1 || fetch_pkt_o !== exp_pkt) begin
            errs++; $display("FAIL post_yumi_fwd got v=%b %h want 1 %h", fetch_v_o, fetch_pkt_o, exp_pkt); end
        exp_stale = STATS ? 16'd2 : 16'd0;
        cmp++; if (stat_stale_drop_o !== exp_stale) begin errs++; $display("FAIL stale_count got %0d want %0d", stat_stale_drop_o, exp_stale); end
        idle_inputs();
    endtask

    task automatic test_full_attaboy();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_v = 1'b1; req_cmd = mk_cmd(OP_ITLB_FENCE);
            #1;
            cmp++; if (req_ready_and_o !== 1'b1) begin errs++; $display("FAIL fence_ready[%0d] got %b want 1", i, req_ready_and_o); end
            cmd_q.push_back(req_cmd);
        end
        @(negedge clk);
        req_cmd = mk_cmd(OP_REDIRECT);
        #1;
        cmp++; if (req_ready_and_o !== 1'b0) begin errs++; $display("FAIL full_redirect_ready got %b want 0", req_ready_and_o); end
        req_cmd = mk_cmd(OP_ATTABOY);
        #1;
        cmp++; if (req_ready_and_o !== 1'b1) begin errs++; $display("FAIL full_attaboy_ready got %b want 1", req_ready_and_o); end
        @(negedge clk);
        req_v = 1'b0;
        #1;
        exp_attaboy = STATS ? 16'd1 : 16'd0;
        cmp++; if (stat_attaboy_drop_o !== exp_attaboy) begin errs++; $display("FAIL attaboy_drop got %0d want %0d", stat_attaboy_drop_o, exp_attaboy); end
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            fe_cmd_yumi = 1'b1;
            #1;
            cmp++; exp_cmd = (cmd_q.size() != 0) ? cmd_q.pop_front() : 'x;
            if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== exp_cmd) begin
                errs++; $display("FAIL drain[%0d] got v=%b %h want 1 %h", i, fe_cmd_v_o, fe_cmd_o, exp_cmd); end
        end
        @(negedge clk);
        fe_cmd_yumi = 1'b0;
        #1;
        cmp++; if (fe_cmd_v_o !== 1'b0 || fe_quiesced_o !== 1'b1) begin
            errs++; $display("FAIL drain_done got v=%b q=%b want 0/1", fe_cmd_v_o, fe_quiesced_o); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_v = 1'b1; req_cmd = mk_cmd(OP_REDIRECT);
        #1;
        cmd_q.push_back(req_cmd);
        @(negedge clk);
        req_cmd = mk_cmd(OP_ICACHE_FILL); fe_cmd_yumi = 1'b1; fe_queue_v = 1'b1; fe_queue = mk_pkt();
        #1;
        cmp++; exp_cmd = (cmd_q.size() != 0) ? cmd_q.pop_front() : 'x;
        if (fe_cmd_o !== exp_cmd) begin errs++; $display("FAIL b2b_redirect got %h want %h", fe_cmd_o, exp_cmd); end
        cmp++; if (req_ready_and_o !== 1'b1) begin errs++; $display("FAIL b2b_fill_ready got %b want 1", req_ready_and_o); end
        cmd_q.push_back(req_cmd);
        @(negedge clk);
        req_v = 1'b0; fe_cmd_yumi = 1'b0; fe_queue = mk_pkt();
        #1;
        cmp++; if (fetch_v_o !== 1'b0 || fe_quiesced_o !== 1'b0) begin
            errs++; $display("FAIL b2b_still_flush got v=%b q=%b want 0/0", fetch_v_o, fe_quiesced_o); end
        @(negedge clk);
        fe_cmd_yumi = 1'b1; fe_queue = mk_pkt();
        #1;
        cmp++; exp_cmd = (cmd_q.size() != 0) ? cmd_q.pop_front() : 'x;
        if (fe_cmd_o !== exp_cmd) begin errs++; $display("FAIL b2b_fill got %h want %h", fe_cmd_o, exp_cmd); end
        cmp++; if (fetch_v_o !== 1'b0) begin errs++; $display("FAIL final_yumi_beat got %b want 0", fetch_v_o); end
        @(negedge clk);
        fe_cmd_yumi = 1'b0; fe_queue = mk_pkt();
        pkt_q.push_back(fe_queue);
        #1;
        cmp++; exp_pkt = (pkt_q.size() != 0) ? pkt_q.pop_front() : 'x;
        if (fetch_v_o !== 1'b1 || fetch_pkt_o !== exp_pkt) begin
            errs++; $display("FAIL b2b_resume got v=%b %h want 1 %h", fetch_v_o, fetch_pkt_o, exp_pkt); end
        exp_stale = STATS ? 16'd5 : 16'd0;
        cmp++; if (stat_stale_drop_o !== exp_stale) begin errs++; $display("FAIL b2b_stale_count got %0d want %0d", stat_stale_drop_o, exp_stale); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req_v = 1'b1; req_cmd = mk_cmd(OP_REDIRECT);
        @(negedge clk);
        req_v = 1'b0;
        #1;
        cmp++; if (fe_cmd_v_o !== 1'b1) begin errs++; $display("FAIL pre_reset_cmd_v got %b want 1", fe_cmd_v_o); end
        #2 reset_n = 1'b0;
        #1;
        cmp++; if (fe_cmd_v_o !== 1'b0 || fe_quiesced_o !== 1'b0) begin
            errs++; $display("FAIL async_reset got v=%b q=%b want 0/0", fe_cmd_v_o, fe_quiesced_o); end
        cmp++; if (stat_attaboy_drop_o !== 16'd0 || stat_stale_drop_o !== 16'd0) begin
            errs++; $display("FAIL async_reset_stats got %0d/%0d want 0/0", stat_attaboy_drop_o, stat_stale_drop_o); end
        cmd_q.delete();
        @(negedge clk) reset_n = 1'b1;
        req_v = 1'b1; req_cmd = mk_cmd(OP_REDIRECT); fetch_ready_and = 1'b0;
        #1;
        cmp++; if (req_ready_and_o !== 1'b0 || fe_queue_ready_and_o !== 1'b1) begin
            errs++; $display("FAIL post_reset_state got rdy=%b qrdy=%b want 0/1", req_ready_and_o, fe_queue_ready_and_o); end
        req_cmd = mk_cmd(OP_STATE_RESET);
        #1;
        cmp++; if (req_ready_and_o !== 1'b1) begin errs++; $display("FAIL post_reset_state_reset got %b want 1", req_ready_and_o); end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_state_reset();
        test_forward();
        test_stale_discard();
        test_full_attaboy();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
